// File: rtl/pulse_sequence_scheduler.sv
// Reset/Write/Measure pulse-train sequencer.
// Double-buffered duration table; commits land only while idle or at a cycle boundary.
module pulse_sequence_scheduler #(
  parameter int DUR_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [DUR_W-1:0] cfg_data,
  input  logic             cfg_commit,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] repeat_count,
  output logic [7:0]       pattern_out,
  output logic [3:0]       step_index,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_done,
  output logic             cfg_pending,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state_q;
  logic [3:0]       step_q;
  logic [DUR_W-1:0] timer_q;
  logic [7:0]       pat_q;
  logic             busy_q, done_q, pend_q, err_q;
  logic [CNT_W-1:0] cyc_q, cnt_q;
  logic [DUR_W-1:0] shadow_q [12];
  logic [DUR_W-1:0] active_q [12];

  logic             wr_ok, step_end, stopping, last, hit;
  logic             wrap, finish, commit_now;
  logic [CNT_W-1:0] cyc_inc;
  logic [3:0]       nxt;
  logic [DUR_W-1:0] fwd0, dur0, dur_nxt;

  function automatic logic [7:0] step_pat(input logic [3:0] s);
    case (s)
      4'd0:        return 8'h88;
      4'd2:        return 8'h90;
      4'd4, 4'd10: return 8'h84;
      4'd6:        return 8'hA0;
      4'd8:        return 8'h82;
      default:     return 8'h80;
    endcase
  endfunction

  // Down-counter reload: a zero duration still occupies one cycle.
  function automatic logic [DUR_W-1:0] load(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  always_comb begin
    wr_ok    = cfg_we && (cfg_addr < 4'd12);
    step_end = busy_q && (timer_q == '0);
    stopping = (state_q == STOPPING) || (state_q == RUN && stop);
    last     = (step_q == 4'd11);
    cyc_inc  = cyc_q + CNT_W'(1);
    hit      = (cnt_q != '0) && (cyc_inc == cnt_q);
    wrap     = step_end && last;
    finish   = step_end && (last ? (stopping || hit)
                                 : (stopping && step_q[0]));
    commit_now = busy_q ? ((pend_q || cfg_commit) && (wrap || finish))
                        : cfg_commit;
    // A write landing on the commit edge is part of the committed table.
    fwd0     = (wr_ok && cfg_addr == 4'd0) ? cfg_data : shadow_q[0];
    dur0     = commit_now ? fwd0 : active_q[0];
    nxt      = last ? 4'd0 : step_q + 4'd1;
    dur_nxt  = last ? dur0 : active_q[nxt];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 12; i++) begin
        shadow_q[i] <= DUR_W'(1);
        active_q[i] <= DUR_W'(1);
      end
    end else begin
      if (wr_ok) shadow_q[cfg_addr] <= cfg_data;
      if (commit_now) begin
        for (int i = 0; i < 12; i++) begin
          active_q[i] <= (wr_ok && cfg_addr == 4'(i)) ? cfg_data
                                                      : shadow_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      step_q  <= '0;
      timer_q <= '0;
      pat_q   <= 8'h80;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= cfg_we && !wr_ok;
      if (!busy_q || wrap || finish) pend_q <= 1'b0;
      else if (cfg_commit)           pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            step_q  <= '0;
            timer_q <= load(dur0);
            pat_q   <= 8'h88;
            cyc_q   <= '0;
            cnt_q   <= repeat_count;
          end
        end
        default: begin
          if (!step_end) begin
            timer_q <= timer_q - DUR_W'(1);
            if (stopping) state_q <= STOPPING;
          end else begin
            if (last) cyc_q <= cyc_inc;
            if (finish) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              step_q  <= '0;
              pat_q   <= 8'h80;
              done_q  <= last && hit && !stopping;
            end else begin
              state_q <= stopping ? STOPPING : RUN;
              step_q  <= nxt;
              pat_q   <= step_pat(nxt);
              timer_q <= load(dur_nxt);
            end
          end
        end
      endcase
    end
  end

  assign pattern_out = pat_q;
  assign step_index  = step_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycles_done = cyc_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_pulse_sequence_scheduler.sv
// Scoreboard bench for pulse_sequence_scheduler.
// Expected traces come from a step-list model of the pulse train.
module tb_pulse_sequence_scheduler;

  logic        clk, rst_in;
  logic        cfg_we, cfg_commit, start, stop;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data, repeat_count;
  logic [7:0]  pattern_out;
  logic [3:0]  step_index;
  logic        busy, done, cfg_pending, cfg_err;
  logic [15:0] cycles_done;

  pulse_sequence_scheduler #(.DUR_W(16), .CNT_W(16)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .start(start), .stop(stop),
    .repeat_count(repeat_count),
    .pattern_out(pattern_out), .step_index(step_index),
    .busy(busy), .done(done), .cycles_done(cycles_done),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  step;
    logic        done;
    logic [15:0] cyc;
    logic        pend;
  } rec_t;

  logic [7:0] PAT [12] = '{8'h88, 8'h80, 8'h90, 8'h80, 8'h84, 8'h80,
                           8'hA0, 8'h80, 8'h82, 8'h80, 8'h84, 8'h80};

  rec_t sb[$];
  rec_t e;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1;
  int   shadow_m [12];
  int   active_m [12];

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (mon_en && !rst_in && (busy || done)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: pat %0h step %0d busy %b done %b, expected no output",
                 pattern_out, step_index, busy, done);
      end else begin
        e = sb.pop_front();
        if (pattern_out !== e.pat || step_index !== e.step ||
            done !== e.done || busy !== !e.done ||
            cycles_done !== e.cyc || cfg_pending !== e.pend) begin
          fails++;
          $display("FAIL trace: got pat %0h step %0d busy %b done %b cyc %0d pend %b, expected pat %0h step %0d busy %b done %b cyc %0d pend %b",
                   pattern_out, step_index, busy, done, cycles_done, cfg_pending,
                   e.pat, e.step, !e.done, e.done, e.cyc, e.pend);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_write(input int a, input int d);
    cfg_we = 1; cfg_addr = 4'(a); cfg_data = 16'(d);
    tick();
    cfg_we = 0;
    if (a < 12) shadow_m[a] = d;
  endtask

  task automatic idle_commit();
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    active_m = shadow_m;
  endtask

  // Model: walk the step list sequence by sequence, then drive the stimulus.
  task automatic run(input int cnt, input int s_seq, input int s_step,
                     input int c_seq, input int c_step,
                     input int wa, input int wd, input bit smid);
    int tbl [12];
    int sh [12];
    int pos, m, d, stop_idx, com_idx, n;
    bit pend, stopping, ended;
    rec_t r;
    tbl = active_m; sh = shadow_m;
    pos = 0; m = 0; pend = 0; stopping = 0; ended = 0;
    stop_idx = -1; com_idx = -1;
    while (!ended && pos < 3000) begin
      for (int k = 0; k < 12 && !ended; k++) begin
        d = (tbl[k] < 1) ? 1 : tbl[k];
        for (int j = 0; j < d; j++) begin
          r.pat = PAT[k]; r.step = 4'(k); r.done = 0;
          r.cyc = 16'(m); r.pend = pend;
          sb.push_back(r);
          if (m == c_seq && k == c_step && j == 0) begin
            com_idx = pos; pend = 1;
            if (wa >= 0) sh[wa] = wd;
          end
          if (!stopping && m == s_seq && k == s_step && j == 0) begin
            stop_idx = pos; stopping = 1;
          end
          pos++;
        end
        if (k == 11) begin
          m++;
          if (pend) begin tbl = sh; pend = 0; end
          if (stopping) ended = 1;
          else if (cnt != 0 && m == cnt) begin
            r.pat = 8'h80; r.step = 0; r.done = 1;
            r.cyc = 16'(m); r.pend = 0;
            sb.push_back(r);
            ended = 1;
          end
        end else if (stopping && (k % 2) == 1) begin
          ended = 1;
        end
      end
    end
    if (pend) tbl = sh;
    active_m = tbl; shadow_m = sh;

    repeat_count = 16'(cnt);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < pos; i++) begin
      if (i == stop_idx) stop = 1;
      if (i == com_idx) begin
        cfg_commit = 1;
        if (wa >= 0) begin
          cfg_we = 1; cfg_addr = 4'(wa); cfg_data = 16'(wd);
        end
      end
      if (smid && i == 1) start = 1;
      tick();
      stop = 0; cfg_commit = 0; cfg_we = 0; start = 0;
    end
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
    chk("end_busy", busy, 0);
    chk("end_pattern", pattern_out, 8'h80);
    chk("end_cycles", cycles_done, 16'(m));
    chk("end_pending", cfg_pending, 0);
  endtask

  initial begin
    int cnt, ss, sst, cs, cst, wa, wd;
    rst_in = 0; cfg_we = 0; cfg_commit = 0; start = 0; stop = 0;
    cfg_addr = 0; cfg_data = 0; repeat_count = 0;
    for (int i = 0; i < 12; i++) begin shadow_m[i] = 1; active_m[i] = 1; end
    #2 rst_in = 1;
    #1;
    chk("rst_pattern", pattern_out, 8'h80);
    chk("rst_step", step_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles_done, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_err", cfg_err, 0);
    tick();
    tick();
    rst_in = 0;
    tick();

    run(1, -1, -1, -1, -1, -1, 0, 0);

    idle_write(0, 5);
    idle_write(2, 0);
    idle_commit();
    chk("idle_commit_pending", cfg_pending, 0);
    run(2, -1, -1, -1, -1, -1, 0, 0);

    run(0, 1, 6, 0, 3, 4, 7, 0);

    idle_write(2, 4);
    idle_commit();
    run(0, 0, 2, -1, -1, -1, 0, 1);

    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    repeat (3) tick();
    chk("start_stop_busy", busy, 0);

    cfg_we = 1; cfg_addr = 4'd12; cfg_data = 16'd9;
    tick();
    cfg_we = 0;
    chk("cfg_err_pulse", cfg_err, 1);
    tick();
    chk("cfg_err_clear", cfg_err, 0);
    idle_commit();
    run(1, -1, -1, -1, -1, -1, 0, 0);

    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < 12; a++)
        if ($urandom_range(0, 2) == 0) idle_write(a, $urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) idle_commit();
      cnt = $urandom_range(0, 3);
      ss = -1; sst = 0;
      if (cnt == 0 || $urandom_range(0, 1) == 1) begin
        ss = $urandom_range(0, (cnt == 0) ? 1 : cnt - 1);
        sst = $urandom_range(0, 11);
      end
      cs = -1; cst = 0; wa = -1; wd = 0;
      if ($urandom_range(0, 1) == 1) begin
        cs = 0; cst = $urandom_range(0, 11);
        wa = $urandom_range(0, 11); wd = $urandom_range(0, 3);
      end
      run(cnt, ss, sst, cs, cst, wa, wd, 1);
    end

    mon_en = 0;
    repeat_count = 0;
    start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    cfg_we = 1; cfg_addr = 4'd3; cfg_data = 16'd9; cfg_commit = 1;
    tick();
    cfg_we = 0; cfg_commit = 0;
    chk("mid_pending", cfg_pending, 1);
    #2 rst_in = 1;
    #1;
    chk("arst_pattern", pattern_out, 8'h80);
    chk("arst_busy", busy, 0);
    chk("arst_step", step_index, 0);
    chk("arst_cycles", cycles_done, 0);
    chk("arst_pending", cfg_pending, 0);
    tick();
    rst_in = 0;
    for (int i = 0; i < 12; i++) begin shadow_m[i] = 1; active_m[i] = 1; end
    sb.delete();
    tick();
    mon_en = 1;
    run(1, -1, -1, -1, -1, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
